// File: rtl/logic_func_unit.sv
// Registered F1/F2/F4 Boolean function unit with an exhaustive 4-bit sweep
// generator for bring-up; vector bit 3 is A, bit 0 is D.

module lfu_func (
  input  logic [3:0] v,
  output logic       f1,
  output logic       f2,
  output logic       f4
);
  // Pure sum-of-products gate logic on {A,B,C,D}
  assign f1 = (v[3] & ~v[2]) | (~v[3] & v[2]);
  assign f2 = ~v[3] | v[2];
  assign f4 = (~v[2] & ~v[0]) | (v[1] & v[0]);
endmodule

module logic_func_unit #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sweep_en,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] vec,
  output logic       f1,
  output logic       f2,
  output logic       f4,
  output logic       sweep_done
);
  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);

  logic [7:0] dw_cnt;
  logic [3:0] sw_cnt;
  logic       wrap_q;
  logic [3:0] app_vec;
  logic       f1_c, f2_c, f4_c;
  logic       dw_last;

  assign app_vec = sweep_en ? sw_cnt : {a, b, c, d};
  assign dw_last = (dw_cnt == DW_LAST);

  lfu_func u_func (
    .v  (app_vec),
    .f1 (f1_c),
    .f2 (f2_c),
    .f4 (f4_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      f1         <= 1'b0;
      f2         <= 1'b0;
      f4         <= 1'b0;
      dw_cnt     <= '0;
      sw_cnt     <= '0;
      wrap_q     <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      vec <= app_vec;
      f1  <= f1_c;
      f2  <= f2_c;
      f4  <= f4_c;
      if (!sweep_en) begin
        dw_cnt     <= '0;
        sw_cnt     <= '0;
        wrap_q     <= 1'b0;
        sweep_done <= 1'b0;
      end else begin
        if (dw_last) begin
          dw_cnt <= '0;
          sw_cnt <= sw_cnt + 4'd1;
        end else begin
          dw_cnt <= dw_cnt + 8'd1;
        end
        // Pulse is delayed one edge past the 15->0 wrap so it lines up
        // with the first 0000 of the new pass on vec.
        wrap_q     <= dw_last && (sw_cnt == 4'hF);
        sweep_done <= wrap_q;
      end
    end
  end
endmodule

// File: tb/tb_logic_func_unit.sv
// Directed bench for logic_func_unit: one DWELL=4 and one DWELL=1 instance
// share stimulus; expected outputs are queued per edge and popped after it.

module tb_logic_func_unit;
  typedef struct packed {
    logic [3:0] vec;
    logic       f1;
    logic       f2;
    logic       f4;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, sweep_en, a, b, c, d;
  logic [3:0] vec4, vec1;
  logic f1_4, f2_4, f4_4, done4;
  logic f1_1, f2_1, f4_1, done1;

  int vectors = 0;
  int miscompares = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  logic_func_unit #(.DWELL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .sweep_en(sweep_en), .a(a), .b(b), .c(c), .d(d),
    .vec(vec4), .f1(f1_4), .f2(f2_4), .f4(f4_4), .sweep_done(done4)
  );

  logic_func_unit #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sweep_en(sweep_en), .a(a), .b(b), .c(c), .d(d),
    .vec(vec1), .f1(f1_1), .f2(f2_1), .f4(f4_1), .sweep_done(done1)
  );

  // Reference truth table, written from the minterm lists
  function automatic exp_t mk(input logic [3:0] v, input logic done);
    exp_t e;
    e.vec  = v;
    e.f1   = (v >= 4'd4) && (v <= 4'd11);
    e.f2   = !((v >= 4'd8) && (v <= 4'd11));
    e.f4   = v inside {4'd0, 4'd2, 4'd3, 4'd7, 4'd8, 4'd10, 4'd11, 4'd15};
    e.done = done;
    return e;
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed vec=%b f=%b%b%b done=%b expected vec=%b f=%b%b%b done=%b",
             tag, obs.vec, obs.f1, obs.f2, obs.f4, obs.done,
             exp.vec, exp.f1, exp.f2, exp.f4, exp.done);
    end
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z = '0;
    check({tag, "_u4"}, exp_t'({vec4, f1_4, f2_4, f4_4, done4}), z);
    check({tag, "_u1"}, exp_t'({vec1, f1_1, f2_1, f4_1, done1}), z);
    vectors++;
    assert ({u4.dw_cnt, u4.sw_cnt, u1.dw_cnt, u1.sw_cnt} === 24'd0)
    else begin
      miscompares++;
      $error("FAIL %s_cnt observed %h expected 0", tag,
             {u4.dw_cnt, u4.sw_cnt, u1.dw_cnt, u1.sw_cnt});
    end
  endtask

  // One clock: queue expectations for this edge, then pop and compare
  task automatic cyc(input string tag, input exp_t e4, input exp_t e1);
    exp_t x;
    q4.push_back(e4);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    x = q4.pop_front();
    check({tag, "_u4"}, exp_t'({vec4, f1_4, f2_4, f4_4, done4}), x);
    x = q1.pop_front();
    check({tag, "_u1"}, exp_t'({vec1, f1_1, f2_1, f4_1, done1}), x);
  endtask

  task automatic ext(input string tag, input logic [3:0] v);
    {a, b, c, d} = v;
    cyc(tag, mk(v, 1'b0), mk(v, 1'b0));
  endtask

  task automatic sweep(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(tag, mk(4'((k / 4) % 16), (k > 0) && (k % 64 == 0)),
               mk(4'(k % 16), (k > 0) && (k % 16 == 0)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sweep_en = 1'b0;
    {a, b, c, d} = 4'b0000;
    #3;
    check_zero("reset");
    rst_n = 1'b1;

    ext("ext0000", 4'b0000);
    ext("ext1000", 4'b1000);
    ext("ext0100", 4'b0100);
    ext("ext0111", 4'b0111);
    ext("ext1101", 4'b1101);

    // Full sweep and a bit of the second pass; pins set to junk are ignored
    {a, b, c, d} = 4'b1011;
    sweep_en = 1'b1;
    sweep("sweep", 70);

    // One-cycle disable with pins 1111, then restart from 0000
    sweep_en = 1'b0;
    ext("pause", 4'b1111);
    {a, b, c, d} = 4'b0110;
    sweep_en = 1'b1;
    sweep("resume", 37);

    // Now at vector 9 on the DWELL=4 unit; async reset between edges
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    #1 rst_n = 1'b1;
    sweep("rstart", 20);

    if (q4.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $error("FAIL queue_drain observed %0d/%0d expected 0/0", q4.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
